note_trigger_controller: RTL and testbench

Monophonic MIDI-to-envelope front end. Parses a byte stream of MIDI channel messages, tracks the held note, and drives the `note_on`/`note_off` control inputs of the envelope generator. It observes the generator's `busy` output, so a new note is never issued while the previous envelope is still releasing. It sits between the MIDI byte receiver and the envelope generator of one voice.

---
 rtl/note_trigger_controller.sv | 209 ++++++++++++++++++++
 tb/tb_note_trigger_controller.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_trigger_controller.sv
// Monophonic MIDI front end: parses channel note messages into a single-entry event
// register and sequences note_on/note_off pulses for one envelope generator.
module note_trigger_controller #(
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic [7:0] midi_byte,
    input  logic       midi_valid,
    output logic       midi_ready,
    input  logic       busy,
    output logic       note_on,
    output logic       note_off,
    output logic       gate,
    output logic [6:0] note_num,
    output logic [6:0] velocity,
    output logic [1:0] dbg_parse_state_o,
    output logic [2:0] dbg_ctrl_state_o
);

    // Handshake: a byte transfers on a rising edge where midi_valid && midi_ready;
    // midi_ready is low exactly while the event register holds an unconsumed event.

    typedef enum logic [1:0] {
        P_NO_STATUS = 2'd0,
        P_DATA1     = 2'd1,
        P_DATA2     = 2'd2
    } parse_e;

    typedef enum logic [2:0] {
        C_IDLE  = 3'd0,
        C_START = 3'd1,
        C_HELD  = 3'd2,
        C_STOP  = 3'd3,
        C_DRAIN = 3'd4
    } ctrl_e;

    parse_e     parse_q, parse_d;
    logic       stat_on_q, stat_on_d;
    logic [6:0] note_lat_q, note_lat_d;

    logic       evt_valid_q, evt_valid_d;
    logic       evt_on_q, evt_on_d;
    logic [6:0] evt_note_q, evt_note_d;
    logic [6:0] evt_vel_q, evt_vel_d;

    ctrl_e      ctrl_q, ctrl_d;
    logic       pend_valid_q, pend_valid_d;
    logic [6:0] pend_note_q, pend_note_d;
    logic [6:0] pend_vel_q, pend_vel_d;
    logic [6:0] note_num_q, note_num_d;
    logic [6:0] vel_q, vel_d;

    logic       accept;
    logic       is_note_status;
    logic       evt_take;

    assign accept         = midi_valid && midi_ready;
    assign is_note_status = (midi_byte[7:5] == 3'b100) && (midi_byte[3:0] == CHANNEL);

    // Byte parser with running status. Realtime bytes pass through without effect.
    always_comb begin
        parse_d    = parse_q;
        stat_on_d  = stat_on_q;
        note_lat_d = note_lat_q;
        evt_on_d   = evt_on_q;
        evt_note_d = evt_note_q;
        evt_vel_d  = evt_vel_q;
        evt_valid_d = evt_valid_q && !evt_take;
        if (accept) begin
            if (midi_byte[7]) begin
                if (midi_byte < 8'hF8) begin
                    if (is_note_status) begin
                        stat_on_d = midi_byte[4];
                        parse_d   = P_DATA1;
                    end else begin
                        stat_on_d = 1'b0;
                        parse_d   = P_NO_STATUS;
                    end
                end
            end else begin
                case (parse_q)
                    P_DATA1: begin
                        note_lat_d = midi_byte[6:0];
                        parse_d    = P_DATA2;
                    end
                    P_DATA2: begin
                        evt_valid_d = 1'b1;
                        evt_on_d    = stat_on_q && (midi_byte[6:0] != 7'd0);
                        evt_note_d  = note_lat_q;
                        evt_vel_d   = midi_byte[6:0];
                        parse_d     = P_DATA1;
                    end
                    default: parse_d = P_NO_STATUS;
                endcase
            end
        end
    end

    // Note controller. Pending holds the note waiting to be started.
    always_comb begin
        ctrl_d       = ctrl_q;
        pend_valid_d = pend_valid_q;
        pend_note_d  = pend_note_q;
        pend_vel_d   = pend_vel_q;
        note_num_d   = note_num_q;
        vel_d        = vel_q;
        evt_take     = 1'b0;
        case (ctrl_q)
            C_IDLE: begin
                if (evt_valid_q) begin
                    evt_take = 1'b1;
                    if (evt_on_q) begin
                        pend_valid_d = 1'b1;
                        pend_note_d  = evt_note_q;
                        pend_vel_d   = evt_vel_q;
                        ctrl_d       = busy ? C_DRAIN : C_START;
                    end
                end
            end
            C_START: begin
                pend_valid_d = 1'b0;
                ctrl_d       = C_HELD;
            end
            C_HELD: begin
                if (evt_valid_q) begin
                    evt_take = 1'b1;
                    if (evt_on_q) begin
                        pend_valid_d = 1'b1;
                        pend_note_d  = evt_note_q;
                        pend_vel_d   = evt_vel_q;
                        ctrl_d       = C_STOP;
                    end else if (evt_note_q == note_num_q) begin
                        pend_valid_d = 1'b0;
                        ctrl_d       = C_STOP;
                    end
                end
            end
            C_STOP: begin
                ctrl_d = pend_valid_q ? C_DRAIN : C_IDLE;
            end
            C_DRAIN: begin
                // An event in the same cycle as busy falling is applied first.
                if (evt_valid_q) begin
                    evt_take = 1'b1;
                    if (evt_on_q) begin
                        pend_valid_d = 1'b1;
                        pend_note_d  = evt_note_q;
                        pend_vel_d   = evt_vel_q;
                    end else if (evt_note_q == pend_note_q) begin
                        pend_valid_d = 1'b0;
                    end
                end
                if (!pend_valid_d) begin
                    ctrl_d = C_IDLE;
                end else if (!busy) begin
                    ctrl_d = C_START;
                end
            end
            default: ctrl_d = C_IDLE;
        endcase
        if (ctrl_d == C_START) begin
            note_num_d = pend_note_d;
            vel_d      = pend_vel_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            parse_q      <= P_NO_STATUS;
            stat_on_q    <= 1'b0;
            note_lat_q   <= 7'd0;
            evt_valid_q  <= 1'b0;
            evt_on_q     <= 1'b0;
            evt_note_q   <= 7'd0;
            evt_vel_q    <= 7'd0;
            ctrl_q       <= C_IDLE;
            pend_valid_q <= 1'b0;
            pend_note_q  <= 7'd0;
            pend_vel_q   <= 7'd0;
            note_num_q   <= 7'd0;
            vel_q        <= 7'd0;
        end else begin
            parse_q      <= parse_d;
            stat_on_q    <= stat_on_d;
            note_lat_q   <= note_lat_d;
            evt_valid_q  <= evt_valid_d;
            evt_on_q     <= evt_on_d;
            evt_note_q   <= evt_note_d;
            evt_vel_q    <= evt_vel_d;
            ctrl_q       <= ctrl_d;
            pend_valid_q <= pend_valid_d;
            pend_note_q  <= pend_note_d;
            pend_vel_q   <= pend_vel_d;
            note_num_q   <= note_num_d;
            vel_q        <= vel_d;
        end
    end

    assign midi_ready        = !evt_valid_q;
    assign note_on           = (ctrl_q == C_START);
    assign note_off          = (ctrl_q == C_STOP);
    assign gate              = (ctrl_q == C_START) || (ctrl_q == C_HELD);
    assign note_num          = note_num_q;
    assign velocity          = vel_q;
    assign dbg_parse_state_o = parse_q;
    assign dbg_ctrl_state_o  = ctrl_q;

endmodule

// File: tb/tb_note_trigger_controller.sv
// Directed bench for note_trigger_controller: parsing, pulse timing, drain/retrigger, reset.
module tb_note_trigger_controller;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_HELD  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic       clk;
    logic       rst_b;
    logic [7:0] midi_byte;
    logic       midi_valid;
    logic       midi_ready;
    logic       busy;
    logic       note_on;
    logic       note_off;
    logic       gate;
    logic [6:0] note_num;
    logic [6:0] velocity;
    logic [1:0] dbg_parse_state;
    logic [2:0] dbg_ctrl_state;

    int errors = 0;
    int checks = 0;
    int on_cnt = 0;
    int off_cnt = 0;
    int both_cnt = 0;

    note_trigger_controller #(.CHANNEL(4'd0)) dut (
        .clk               (clk),
        .rst_b             (rst_b),
        .midi_byte         (midi_byte),
        .midi_valid        (midi_valid),
        .midi_ready        (midi_ready),
        .busy              (busy),
        .note_on           (note_on),
        .note_off          (note_off),
        .gate              (gate),
        .note_num          (note_num),
        .velocity          (velocity),
        .dbg_parse_state_o (dbg_parse_state),
        .dbg_ctrl_state_o  (dbg_ctrl_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (note_on === 1'b1) on_cnt++;
        if (note_off === 1'b1) off_cnt++;
        if (note_on === 1'b1 && note_off === 1'b1) both_cnt++;
    end

    // Presents a byte from a falling edge and holds it until the rising edge that accepts it.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        midi_byte  = b;
        midi_valid = 1'b1;
        while (midi_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (midi_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout byte=%02h midi_ready=%b required=1", b, midi_ready);
        end
        @(posedge clk);
        #1 midi_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_b = 1'b0; midi_valid = 1'b1; midi_byte = 8'h90; busy = 1'b0;
        wait_cycles(2);
        checks++;
        if ({midi_ready, note_on, note_off, gate, note_num, velocity} !== {1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0}) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b on=%b off=%b gate=%b num=%0d vel=%0d required 1,0,0,0,0,0",
                     midi_ready, note_on, note_off, gate, note_num, velocity);
        end
        midi_valid = 1'b0;
        rst_b = 1'b1;
        wait_cycles(2);
        checks++;
        if (on_cnt !== 0 || off_cnt !== 0 || dbg_ctrl_state !== S_IDLE) begin
            errors++;
            $display("FAIL reset_no_pulse got on=%0d off=%0d state=%0d required 0,0,0", on_cnt, off_cnt, dbg_ctrl_state);
        end
    endtask

    task automatic test_basic_note;
        int on0, off0;
        on0 = on_cnt; off0 = off_cnt;
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        @(negedge clk);
        checks++;
        if (note_on !== 1'b0 || midi_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_t1 got on=%b rdy=%b required on=0 rdy=0", note_on, midi_ready);
        end
        @(negedge clk);
        checks++;
        if ({note_on, gate, note_num, velocity, midi_ready} !== {1'b1, 1'b1, 7'd60, 7'd100, 1'b1}) begin
            errors++;
            $display("FAIL basic_t2 got on=%b gate=%b num=%0d vel=%0d rdy=%b required 1,1,60,100,1",
                     note_on, gate, note_num, velocity, midi_ready);
        end
        @(negedge clk);
        checks++;
        if (note_on !== 1'b0 || gate !== 1'b1 || dbg_ctrl_state !== S_HELD) begin
            errors++;
            $display("FAIL basic_t3 got on=%b gate=%b state=%0d required 0,1,%0d", note_on, gate, dbg_ctrl_state, S_HELD);
        end
        send_byte(8'h80); send_byte(8'h3D); send_byte(8'h00);
        wait_cycles(4);
        checks++;
        if (gate !== 1'b1 || off_cnt !== off0 || dbg_ctrl_state !== S_HELD) begin
            errors++;
            $display("FAIL basic_other_off got gate=%b offs=%0d state=%0d required 1,%0d,%0d",
                     gate, off_cnt - off0, dbg_ctrl_state, 0, S_HELD);
        end
        send_byte(8'h80); send_byte(8'h3C); send_byte(8'h00);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (note_off !== 1'b1 || gate !== 1'b0 || note_on !== 1'b0) begin
            errors++;
            $display("FAIL basic_off_pulse got off=%b gate=%b on=%b required 1,0,0", note_off, gate, note_on);
        end
        @(negedge clk);
        checks++;
        if (note_off !== 1'b0 || dbg_ctrl_state !== S_IDLE || on_cnt - on0 !== 1 || off_cnt - off0 !== 1) begin
            errors++;
            $display("FAIL basic_end got off=%b state=%0d ons=%0d offs=%0d required 0,0,1,1",
                     note_off, dbg_ctrl_state, on_cnt - on0, off_cnt - off0);
        end
    endtask

    task automatic test_running_status;
        int on0, off0;
        on0 = on_cnt; off0 = off_cnt;
        send_byte(8'h90); send_byte(8'h40); send_byte(8'h50); send_byte(8'h40); send_byte(8'h00);
        wait_cycles(6);
        checks++;
        if (on_cnt - on0 !== 1 || off_cnt - off0 !== 1 || note_num !== 7'd64 || velocity !== 7'd80
            || gate !== 1'b0 || dbg_ctrl_state !== S_IDLE) begin
            errors++;
            $display("FAIL running_status got ons=%0d offs=%0d num=%0d vel=%0d gate=%b state=%0d required 1,1,64,80,0,0",
                     on_cnt - on0, off_cnt - off0, note_num, velocity, gate, dbg_ctrl_state);
        end
    endtask

    task automatic test_other_channel;
        int on0, off0;
        on0 = on_cnt; off0 = off_cnt;
        send_byte(8'h91); send_byte(8'h3C); send_byte(8'h64); send_byte(8'h3D); send_byte(8'h64);
        wait_cycles(4);
        checks++;
        if (on_cnt !== on0 || off_cnt !== off0 || gate !== 1'b0 || dbg_parse_state !== 2'd0) begin
            errors++;
            $display("FAIL other_channel got ons=%0d offs=%0d gate=%b parse=%0d required 0,0,0,0",
                     on_cnt - on0, off_cnt - off0, gate, dbg_parse_state);
        end
    endtask

    task automatic test_retrigger;
        int on0;
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        wait_cycles(3);
        busy = 1'b1;
        on0 = on_cnt;
        send_byte(8'h90); send_byte(8'h43); send_byte(8'h7F);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (note_off !== 1'b1 || gate !== 1'b0) begin
            errors++;
            $display("FAIL retrig_off got off=%b gate=%b required 1,0", note_off, gate);
        end
        @(negedge clk);
        checks++;
        if (dbg_ctrl_state !== S_DRAIN || note_off !== 1'b0) begin
            errors++;
            $display("FAIL retrig_drain got state=%0d off=%b required %0d,0", dbg_ctrl_state, note_off, S_DRAIN);
        end
        wait_cycles(10);
        checks++;
        if (on_cnt !== on0 || dbg_ctrl_state !== S_DRAIN || note_on !== 1'b0) begin
            errors++;
            $display("FAIL retrig_wait got ons=%0d state=%0d on=%b required 0,%0d,0", on_cnt - on0, dbg_ctrl_state, note_on, S_DRAIN);
        end
        busy = 1'b0;
        @(negedge clk);
        checks++;
        if ({note_on, gate, note_num, velocity} !== {1'b1, 1'b1, 7'd67, 7'd127}) begin
            errors++;
            $display("FAIL retrig_on got on=%b gate=%b num=%0d vel=%0d required 1,1,67,127", note_on, gate, note_num, velocity);
        end
        busy = 1'b1;
        @(negedge clk);
        checks++;
        if (note_on !== 1'b0 || dbg_ctrl_state !== S_HELD) begin
            errors++;
            $display("FAIL retrig_held got on=%b state=%0d required 0,%0d", note_on, dbg_ctrl_state, S_HELD);
        end
    endtask

    task automatic test_drain_cancel;
        int on0;
        on0 = on_cnt;
        send_byte(8'h90); send_byte(8'h48); send_byte(8'h40);
        wait_cycles(3);
        checks++;
        if (dbg_ctrl_state !== S_DRAIN) begin
            errors++;
            $display("FAIL cancel_drain got state=%0d required %0d", dbg_ctrl_state, S_DRAIN);
        end
        send_byte(8'h45); send_byte(8'h30);
        send_byte(8'h45); send_byte(8'h00);
        wait_cycles(3);
        checks++;
        if (dbg_ctrl_state !== S_IDLE || gate !== 1'b0 || on_cnt !== on0 || note_num !== 7'd67) begin
            errors++;
            $display("FAIL cancel_idle got state=%0d gate=%b ons=%0d num=%0d required 0,0,0,67",
                     dbg_ctrl_state, gate, on_cnt - on0, note_num);
        end
        busy = 1'b0;
        wait_cycles(4);
        checks++;
        if (on_cnt !== on0 || dbg_ctrl_state !== S_IDLE) begin
            errors++;
            $display("FAIL cancel_quiet got ons=%0d state=%0d required 0,0", on_cnt - on0, dbg_ctrl_state);
        end
    endtask

    task automatic test_drain_replace;
        int on0;
        busy = 1'b1;
        on0 = on_cnt;
        send_byte(8'h90); send_byte(8'h30); send_byte(8'h10);
        send_byte(8'h32); send_byte(8'h20);
        wait_cycles(3);
        checks++;
        if (dbg_ctrl_state !== S_DRAIN || on_cnt !== on0) begin
            errors++;
            $display("FAIL replace_drain got state=%0d ons=%0d required %0d,0", dbg_ctrl_state, on_cnt - on0, S_DRAIN);
        end
        busy = 1'b0;
        @(negedge clk);
        checks++;
        if ({note_on, note_num, velocity} !== {1'b1, 7'h32, 7'h20}) begin
            errors++;
            $display("FAIL replace_on got on=%b num=%0d vel=%0d required 1,50,32", note_on, note_num, velocity);
        end
        send_byte(8'h80); send_byte(8'h32); send_byte(8'h00);
        wait_cycles(4);
        checks++;
        if (dbg_ctrl_state !== S_IDLE || gate !== 1'b0 || on_cnt - on0 !== 1) begin
            errors++;
            $display("FAIL replace_end got state=%0d gate=%b ons=%0d required 0,0,1", dbg_ctrl_state, gate, on_cnt - on0);
        end
    endtask

    task automatic test_realtime;
        send_byte(8'h90); send_byte(8'hF8); send_byte(8'h3C); send_byte(8'hFE); send_byte(8'h64);
        @(negedge clk);
        checks++;
        if (note_on !== 1'b0) begin
            errors++;
            $display("FAIL realtime_t1 got on=%b required 0", note_on);
        end
        @(negedge clk);
        checks++;
        if ({note_on, gate, note_num, velocity} !== {1'b1, 1'b1, 7'd60, 7'd100}) begin
            errors++;
            $display("FAIL realtime_t2 got on=%b gate=%b num=%0d vel=%0d required 1,1,60,100", note_on, gate, note_num, velocity);
        end
        wait_cycles(2);
    endtask

    task automatic test_reset_mid;
        int off0;
        off0 = off_cnt;
        rst_b = 1'b0;
        @(negedge clk);
        checks++;
        if ({midi_ready, note_on, note_off, gate, note_num, velocity} !== {1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0}
            || dbg_ctrl_state !== S_IDLE) begin
            errors++;
            $display("FAIL reset_mid got rdy=%b on=%b off=%b gate=%b num=%0d vel=%0d state=%0d required 1,0,0,0,0,0,0",
                     midi_ready, note_on, note_off, gate, note_num, velocity, dbg_ctrl_state);
        end
        rst_b = 1'b1;
        wait_cycles(3);
        checks++;
        if (off_cnt !== off0 || gate !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_quiet got offs=%0d gate=%b required 0,0", off_cnt - off0, gate);
        end
    endtask

    task automatic test_exclusive;
        checks++;
        if (both_cnt !== 0) begin
            errors++;
            $display("FAIL on_off_exclusive got overlap_cycles=%0d required 0", both_cnt);
        end
    endtask

    initial begin
        midi_byte = 8'h00;
        midi_valid = 1'b0;
        busy = 1'b0;
        rst_b = 1'b0;
        test_reset;
        test_basic_note;
        test_running_status;
        test_other_channel;
        test_retrigger;
        test_drain_cancel;
        test_drain_replace;
        test_realtime;
        test_reset_mid;
        test_exclusive;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
